// File: rtl/arith_pkg.sv
// Shared types for the handshaked signed arithmetic unit.
package arith_pkg;

    typedef enum logic [1:0] {
        OP_ADD     = 2'd0,
        OP_SUB     = 2'd1,
        OP_MUL     = 2'd2,
        OP_ABSDIFF = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/arith_unit_if.sv
// Valid/ready operand and result channels of arith_unit; operands are BITS/2 wide, result BITS.
interface arith_unit_if #(
    parameter int unsigned BITS = 16
);
    localparam int unsigned N = BITS / 2;

    logic                   in_valid;
    logic                   in_ready;
    logic [1:0]             op;
    logic signed [N-1:0]    a_in;
    logic signed [N-1:0]    b_in;
    logic                   out_valid;
    logic                   out_ready;
    logic signed [BITS-1:0] result;
    logic                   zero;

    modport master (
        output in_valid, op, a_in, b_in, out_ready,
        input  in_ready, out_valid, result, zero
    );

    modport slave (
        input  in_valid, op, a_in, b_in, out_ready,
        output in_ready, out_valid, result, zero
    );

endinterface

// File: rtl/seq_mult_u.sv
// Unsigned N-bit shift-add multiplier; the start edge also performs the first iteration,
// so the full product is presented (combinationally) while done is high, N-1 cycles later.
module seq_mult_u #(
    parameter int unsigned N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   mcand,
    input  logic [N-1:0]   mplier,
    output logic           done,
    output logic [2*N-1:0] product
);
    localparam int unsigned CntW = (N > 2) ? $clog2(N) : 1;

    logic             busy_q;
    logic [CntW-1:0]  cnt_q;
    logic [N-1:0]     mcand_q;
    logic [2*N-1:0]   p_q;

    logic [2*N-1:0]   src_p;
    logic [N-1:0]     src_m;
    logic [N:0]       sum;
    logic [2*N-1:0]   step;

    // Upper half accumulates partial sums; lower half shifts the multiplier out LSB first.
    always_comb begin
        src_p   = start ? {{N{1'b0}}, mplier} : p_q;
        src_m   = start ? mcand : mcand_q;
        sum     = {1'b0, src_p[2*N-1:N]} + {1'b0, (src_p[0] ? src_m : {N{1'b0}})};
        step    = {sum, src_p[N-1:1]};
        done    = busy_q && (cnt_q == CntW'(N - 2));
        product = step;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            mcand_q <= '0;
            p_q     <= '0;
        end else if (start) begin
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            mcand_q <= mcand;
            p_q     <= step;
        end else if (busy_q) begin
            p_q   <= step;
            cnt_q <= cnt_q + CntW'(1);
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/arith_unit.sv
// Handshaked signed ADD/SUB/MUL/ABSDIFF unit: single-cycle ALU ops, shift-add MUL,
// result held in DONE until the consumer takes it.
module arith_unit
    import arith_pkg::*;
#(
    parameter int unsigned BITS = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    arith_unit_if.slave bus
);
    localparam int unsigned N = BITS / 2;

    typedef struct packed {
        op_e                 op;
        logic signed [N-1:0] a;
        logic signed [N-1:0] b;
    } opnd_t;

    opnd_t                  opnd;
    state_e                 state_q, state_d;
    logic signed [BITS-1:0] result_q, result_d;
    logic                   zero_q, zero_d;
    logic                   sign_q, sign_d;

    logic                   accept;
    logic signed [BITS-1:0] a_ext, b_ext, sum, dif, absdif, alu_res;
    logic [N-1:0]           a_u, b_u, mag_a, mag_b;
    logic                   mul_start, mul_done;
    logic [BITS-1:0]        mul_prod;
    logic signed [BITS-1:0] mul_res;

    always_comb begin
        opnd.op = op_e'(bus.op);
        opnd.a  = bus.a_in;
        opnd.b  = bus.b_in;
    end

    assign bus.in_ready  = (state_q == S_IDLE) && rst_n;
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign accept        = bus.in_valid && bus.in_ready;

    // Full-width arithmetic on sign-extended operands; none of these can overflow BITS.
    always_comb begin
        a_ext  = {{N{opnd.a[N-1]}}, opnd.a};
        b_ext  = {{N{opnd.b[N-1]}}, opnd.b};
        sum    = a_ext + b_ext;
        dif    = a_ext - b_ext;
        absdif = dif[BITS-1] ? -dif : dif;
        case (opnd.op)
            OP_ADD:     alu_res = sum;
            OP_SUB:     alu_res = dif;
            OP_ABSDIFF: alu_res = absdif;
            default:    alu_res = '0;
        endcase
    end

    // |-2^(N-1)| wraps to 2^(N-1), which is exact as an N-bit unsigned magnitude.
    always_comb begin
        a_u     = opnd.a;
        b_u     = opnd.b;
        mag_a   = a_u[N-1] ? -a_u : a_u;
        mag_b   = b_u[N-1] ? -b_u : b_u;
        mul_res = sign_q ? -$signed(mul_prod) : $signed(mul_prod);
    end

    seq_mult_u #(
        .N(N)
    ) u_mult (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .mcand   (mag_a),
        .mplier  (mag_b),
        .done    (mul_done),
        .product (mul_prod)
    );

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        sign_d    = sign_q;
        mul_start = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (opnd.op == OP_MUL) begin
                        mul_start = 1'b1;
                        sign_d    = opnd.a[N-1] ^ opnd.b[N-1];
                        state_d   = S_MUL;
                    end else begin
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        state_d  = S_DONE;
                    end
                end
            end
            S_MUL: begin
                if (mul_done) begin
                    result_d = mul_res;
                    zero_d   = (mul_res == '0);
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            sign_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            sign_q   <= sign_d;
        end
    end

endmodule

// File: tb/tb_arith_unit.sv
// Directed self-checking bench for arith_unit at BITS=16 (N=8).
module tb_arith_unit;

    localparam logic [1:0] ADD = 2'd0;
    localparam logic [1:0] SUB = 2'd1;
    localparam logic [1:0] MUL = 2'd2;
    localparam logic [1:0] ABD = 2'd3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    arith_unit_if #(.BITS(16)) bus ();

    arith_unit #(
        .BITS(16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%h, expected 0x%h", tag, obs, exp);
        end
    endtask

    // Called #1 after a rising edge with the unit idle; returns at the same phase, idle again.
    task automatic run_op(input string tag, input logic [1:0] op, input logic signed [7:0] a,
                          input logic signed [7:0] b, input logic [15:0] exp_res,
                          input logic exp_zero, input int exp_lat);
        int lat;
        check($sformatf("%s.in_ready", tag), {15'd0, bus.in_ready}, 16'd1);
        bus.op       = op;
        bus.a_in     = a;
        bus.b_in     = b;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.op       = ~op;
        bus.a_in     = 8'h55;
        bus.b_in     = 8'hAA;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check($sformatf("%s.latency", tag), 16'(lat), 16'(exp_lat));
        check($sformatf("%s.result", tag), bus.result, exp_res);
        check($sformatf("%s.zero", tag), {15'd0, bus.zero}, {15'd0, exp_zero});
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check($sformatf("%s.out_valid_drop", tag), {15'd0, bus.out_valid}, 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op        = 2'd0;
        bus.a_in      = '0;
        bus.b_in      = '0;

        #2;
        check("rst.out_valid", {15'd0, bus.out_valid}, 16'd0);
        check("rst.result", bus.result, 16'h0000);
        check("rst.zero", {15'd0, bus.zero}, 16'd0);
        check("rst.in_ready", {15'd0, bus.in_ready}, 16'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("t1_add", ADD, 8'sd100, 8'sd27, 16'h007F, 1'b0, 1);
        run_op("t2_sub", SUB, -8'sd128, 8'sd127, 16'hFF01, 1'b0, 1);
        run_op("t2_sub0", SUB, 8'sd5, 8'sd5, 16'h0000, 1'b1, 1);
        run_op("t3_mul_ext", MUL, -8'sd128, -8'sd128, 16'h4000, 1'b0, 8);
        run_op("t3_mul_neg", MUL, -8'sd3, 8'sd7, 16'hFFEB, 1'b0, 8);
        run_op("t3_mul_zero", MUL, 8'sd0, -8'sd77, 16'h0000, 1'b1, 8);
        run_op("t4_abd", ABD, -8'sd5, 8'sd10, 16'h000F, 1'b0, 1);
        run_op("t4_abd_ext", ABD, 8'sd127, -8'sd128, 16'h00FF, 1'b0, 1);

        // Backpressure: hold the 3+4 result while a 9-4 request waits at the input.
        bus.op = ADD; bus.a_in = 8'sd3; bus.b_in = 8'sd4; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        check("t5.out_valid", {15'd0, bus.out_valid}, 16'd1);
        bus.op = SUB; bus.a_in = 8'sd9; bus.b_in = 8'sd4;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check($sformatf("t5.stall%0d.out_valid", i), {15'd0, bus.out_valid}, 16'd1);
            check($sformatf("t5.stall%0d.result", i), bus.result, 16'h0007);
            check($sformatf("t5.stall%0d.zero", i), {15'd0, bus.zero}, 16'd0);
            check($sformatf("t5.stall%0d.in_ready", i), {15'd0, bus.in_ready}, 16'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("t5.release.out_valid", {15'd0, bus.out_valid}, 16'd0);
        check("t5.release.in_ready", {15'd0, bus.in_ready}, 16'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("t5.second.out_valid", {15'd0, bus.out_valid}, 16'd1);
        check("t5.second.result", bus.result, 16'h0005);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;

        // Reset while a multiply is in flight.
        bus.op = MUL; bus.a_in = -8'sd3; bus.b_in = 8'sd7; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6.rst.out_valid", {15'd0, bus.out_valid}, 16'd0);
        check("t6.rst.result", bus.result, 16'h0000);
        check("t6.rst.in_ready", {15'd0, bus.in_ready}, 16'd0);
        @(posedge clk); #1;
        check("t6.rst_hold.in_ready", {15'd0, bus.in_ready}, 16'd0);
        check("t6.rst_hold.out_valid", {15'd0, bus.out_valid}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("t6_add", ADD, 8'sd1, 8'sd1, 16'h0002, 1'b0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
